// File: rtl/msg_schedule.sv
// SHA-2 message schedule: loads 16 words, then expands to W[0..ROUNDS-1] through a 16-entry ring.
// Optional abort input enabled by defining MSG_SCHED_ABORT_EN.
module msg_schedule #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  S_start_in,
    input  logic                  S_word_valid_in,
    input  logic [DATA_WIDTH-1:0] S_word_in,
    output logic                  D_word_ready_out,
    output logic                  D_W_valid_out,
    output logic [DATA_WIDTH-1:0] D_W_out,
    output logic [6:0]            D_t_out,
    input  logic                  S_W_ready_in,
    output logic                  D_done_out,
    input  logic                  S_abort_in
);

    localparam int         ROUNDS   = (DATA_WIDTH == 64) ? 80 : 64;
    localparam logic [6:0] ROUNDS_T = 7'(ROUNDS);
    localparam logic [6:0] LAST_T   = 7'(ROUNDS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

    state_t                state;
    logic [6:0]            t;
    logic [DATA_WIDTH-1:0] w_buf [16];
    logic                  slot_free;
    logic                  consume;
    logic                  abort_req;
    logic                  load_fire;
    logic                  expand_fire;
    logic [3:0]            idx2;
    logic [3:0]            idx7;
    logic [3:0]            idx15;
    logic [DATA_WIDTH-1:0] w_new;

    function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sig0(input logic [DATA_WIDTH-1:0] x);
        if (DATA_WIDTH == 32)
            return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        else
            return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sig1(input logic [DATA_WIDTH-1:0] x);
        if (DATA_WIDTH == 32)
            return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        else
            return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

`ifdef MSG_SCHED_ABORT_EN
    assign abort_req = S_abort_in && ((state == LOAD) || (state == EXPAND));
`else
    assign abort_req = S_abort_in & 1'b0;
`endif

    assign slot_free        = !D_W_valid_out || S_W_ready_in;
    assign consume          = D_W_valid_out && S_W_ready_in;
    assign D_word_ready_out = (state == LOAD) && slot_free;
    assign load_fire        = S_word_valid_in && D_word_ready_out && !abort_req;
    assign expand_fire      = (state == EXPAND) && slot_free && (t < ROUNDS_T) && !abort_req;

    // Ring slot t mod 16 still holds W[t-16]; W[t-15] sits in the next slot.
    assign idx2  = t[3:0] - 4'd2;
    assign idx7  = t[3:0] - 4'd7;
    assign idx15 = t[3:0] + 4'd1;
    assign w_new = sig1(w_buf[idx2]) + w_buf[idx7] + sig0(w_buf[idx15]) + w_buf[t[3:0]];

    always_ff @(posedge clk) begin
        if (load_fire)
            w_buf[t[3:0]] <= S_word_in;
        else if (expand_fire)
            w_buf[t[3:0]] <= w_new;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            t             <= '0;
            D_W_valid_out <= 1'b0;
            D_W_out       <= '0;
            D_t_out       <= '0;
            D_done_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    D_done_out <= 1'b0;
                    if (S_start_in) begin
                        state <= LOAD;
                        t     <= '0;
                    end
                end
                LOAD: begin
                    if (abort_req) begin
                        state         <= IDLE;
                        D_W_valid_out <= 1'b0;
                    end else if (load_fire) begin
                        D_W_out       <= S_word_in;
                        D_t_out       <= t;
                        D_W_valid_out <= 1'b1;
                        t             <= t + 7'd1;
                        if (t == 7'd15)
                            state <= EXPAND;
                    end else if (consume) begin
                        D_W_valid_out <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (abort_req) begin
                        state         <= IDLE;
                        D_W_valid_out <= 1'b0;
                    end else if (consume && (D_t_out == LAST_T)) begin
                        state         <= DONE;
                        D_W_valid_out <= 1'b0;
                        D_done_out    <= 1'b1;
                    end else if (expand_fire) begin
                        D_W_out       <= w_new;
                        D_t_out       <= t;
                        D_W_valid_out <= 1'b1;
                        t             <= t + 7'd1;
                    end else if (consume) begin
                        D_W_valid_out <= 1'b0;
                    end
                end
                DONE: begin
                    D_done_out <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
